// File: rtl/tawas_rcn_mt.sv
// rtl/tawas_rcn_mt.sv - per-thread RCN load/store tracking, stall generation and load writeback
module tawas_rcn_mt #(
  parameter int TID_W        = 2,
  parameter int CNT_W        = 4,
  parameter int MAX_PEND     = 15,
  parameter int SLICE_OFFSET = 3,
  parameter int SEXT_EN      = 1,
  localparam int THREADS     = 1 << TID_W
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic [TID_W-1:0]   slice,
  output logic [THREADS-1:0] thr_stall,

  input  logic               cs,
  input  logic               xch,
  input  logic               wr,
  input  logic               sx,
  input  logic [31:0]        addr,
  input  logic [2:0]         wbreg,
  input  logic [3:0]         mask,
  input  logic [31:0]        wdata,

  output logic               mst_cs,
  output logic [TID_W-1:0]   mst_seq,
  output logic               mst_wr,
  output logic [3:0]         mst_mask,
  output logic [23:0]        mst_addr,
  output logic [31:0]        mst_wdata,

  input  logic               mst_issue,
  input  logic [TID_W-1:0]   mst_iss_seq,
  input  logic               mst_rdone,
  input  logic               mst_wdone,
  input  logic [TID_W-1:0]   mst_rsp_seq,
  input  logic [3:0]         mst_rsp_mask,
  input  logic [31:0]        mst_rsp_data,

  output logic               load_vld,
  output logic [TID_W-1:0]   load_slice,
  output logic [2:0]         load_sel,
  output logic [31:0]        load_data,

  input  logic               err_clr,
  output logic [THREADS-1:0] err_ovf,
  output logic [THREADS-1:0] err_unf
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);
  localparam logic             SEXT_ON  = (SEXT_EN != 0);

  logic [TID_W-1:0]   tag;
  logic [CNT_W-1:0]   pending [THREADS];
  logic [2:0]         wbreg_t [THREADS];
  logic [THREADS-1:0] xch_t;
  logic [THREADS-1:0] sx_t;
  logic [THREADS-1:0] issue_stall;
  logic [THREADS-1:0] pending_stall;
  logic [THREADS-1:0] max_stall;
  logic [THREADS-1:0] inc;
  logic [THREADS-1:0] dec;
  logic [THREADS-1:0] ovf_new;
  logic [THREADS-1:0] unf_new;
  logic               rsp_sx;
  logic [31:0]        aligned;
  logic               unused_addr_hi;

  assign tag = slice + TID_W'(SLICE_OFFSET);

  assign mst_cs    = cs;
  assign mst_seq   = tag;
  assign mst_wr    = wr;
  assign mst_mask  = mask;
  assign mst_addr  = addr[23:0];
  assign mst_wdata = wdata;

  assign unused_addr_hi = ^addr[31:24];

  always_comb begin
    inc       = '0;
    dec       = '0;
    max_stall = '0;
    ovf_new   = '0;
    unf_new   = '0;
    for (int t = 0; t < THREADS; t++) begin
      inc[t]       = cs && (tag == TID_W'(t));
      dec[t]       = (mst_rdone || mst_wdone) && (mst_rsp_seq == TID_W'(t));
      max_stall[t] = (pending[t] == PEND_MAX);
      ovf_new[t]   = inc[t] && !dec[t] && max_stall[t];
      unf_new[t]   = dec[t] && !inc[t] && (pending[t] == '0);
    end
  end

  // Stall is built from registered state only, so cs never reaches thr_stall combinationally.
  assign thr_stall = max_stall | issue_stall | pending_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < THREADS; t++) begin
        pending[t] <= '0;
        wbreg_t[t] <= '0;
      end
      xch_t         <= '0;
      sx_t          <= '0;
      issue_stall   <= '0;
      pending_stall <= '0;
    end else begin
      for (int t = 0; t < THREADS; t++) begin
        if (inc[t] && !dec[t] && !max_stall[t])
          pending[t] <= pending[t] + PEND_ONE;
        else if (dec[t] && !inc[t] && (pending[t] != '0))
          pending[t] <= pending[t] - PEND_ONE;

        // An acceptance in the same cycle as the request means no issue wait at all.
        if (mst_issue && (mst_iss_seq == TID_W'(t)))
          issue_stall[t] <= 1'b0;
        else if (inc[t])
          issue_stall[t] <= 1'b1;

        if (inc[t] && (!wr || xch))
          pending_stall[t] <= 1'b1;
        else if (dec[t] && (pending[t] == PEND_ONE))
          pending_stall[t] <= 1'b0;

        if (inc[t]) begin
          wbreg_t[t] <= wbreg;
          xch_t[t]   <= wr && xch;
          sx_t[t]    <= sx && SEXT_ON;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= '0;
      err_unf <= '0;
    end else begin
      err_ovf <= (err_clr ? '0 : err_ovf) | ovf_new;
      err_unf <= (err_clr ? '0 : err_unf) | unf_new;
    end
  end

  assign rsp_sx = sx_t[mst_rsp_seq];

  always_comb begin
    aligned = {{24{rsp_sx & mst_rsp_data[7]}}, mst_rsp_data[7:0]};
    if (mst_rsp_mask == 4'b1111)
      aligned = mst_rsp_data;
    else if (mst_rsp_mask[3:2] == 2'b11)
      aligned = {{16{rsp_sx & mst_rsp_data[31]}}, mst_rsp_data[31:16]};
    else if (mst_rsp_mask[1:0] == 2'b11)
      aligned = {{16{rsp_sx & mst_rsp_data[15]}}, mst_rsp_data[15:0]};
    else if (mst_rsp_mask[3])
      aligned = {{24{rsp_sx & mst_rsp_data[31]}}, mst_rsp_data[31:24]};
    else if (mst_rsp_mask[2])
      aligned = {{24{rsp_sx & mst_rsp_data[23]}}, mst_rsp_data[23:16]};
    else if (mst_rsp_mask[1])
      aligned = {{24{rsp_sx & mst_rsp_data[15]}}, mst_rsp_data[15:8]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_vld   <= 1'b0;
      load_slice <= '0;
      load_sel   <= '0;
      load_data  <= '0;
    end else begin
      load_vld   <= mst_rdone || (mst_wdone && xch_t[mst_rsp_seq]);
      load_slice <= mst_rsp_seq;
      load_sel   <= wbreg_t[mst_rsp_seq];
      load_data  <= aligned;
    end
  end

endmodule
